// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_fsm
//  Purpose  : Moore control FSM for the multicycle ARM-like CPU. Sequences
//             fetch / decode / execute / memory / writeback over several
//             cycles around one shared ALU and one memory port. Conditional
//             strobes (PCS, RegW, MemW) are requests; the downstream
//             conditional unit gates them with CondEx.
//  Ports    : clk, reset (async, active-high)
//             i_op[1:0], i_funct[5:0], i_rd[3:0]   instruction fields
//             o_state[3:0]                          current state (debug)
//             o_ir_write, o_next_pc                 unconditional strobes
//             o_pcs, o_reg_w, o_mem_w               conditional requests
//             o_adr_src, o_result_src, o_alu_src_a,
//             o_alu_src_b, o_imm_src, o_reg_src     datapath mux selects
//             o_alu_control[ALUCTL_W-1:0], o_flag_w[1:0], o_illegal
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int ALUCTL_W = 3   // 2 or 3; with 2, EOR and CMP are unimplemented
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          i_op,
  input  logic [5:0]          i_funct,
  input  logic [3:0]          i_rd,
  output logic [3:0]          o_state,
  output logic                o_ir_write,
  output logic                o_next_pc,
  output logic                o_pcs,
  output logic                o_reg_w,
  output logic                o_mem_w,
  output logic                o_adr_src,
  output logic [1:0]          o_result_src,
  output logic [1:0]          o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_imm_src,
  output logic [1:0]          o_reg_src,
  output logic [ALUCTL_W-1:0] o_alu_control,
  output logic [1:0]          o_flag_w,
  output logic                o_illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_nowrite_q;
  logic       r_illegal_q;

  // Data-processing decode (independent of state; only used in EXEC).
  logic [2:0] w_alu_code;
  logic       w_dp_legal;
  logic       w_dp_nowrite;
  logic       w_dp_arith;    // ADD/SUB/CMP also update C,V

  always_comb begin
    w_alu_code   = 3'd0;
    w_dp_legal   = 1'b1;
    w_dp_nowrite = 1'b0;
    w_dp_arith   = 1'b0;
    case (i_funct[4:1])
      4'b0100: begin w_alu_code = 3'd0; w_dp_arith = 1'b1; end       // ADD
      4'b0010: begin w_alu_code = 3'd1; w_dp_arith = 1'b1; end       // SUB
      4'b0000: w_alu_code = 3'd2;                                     // AND
      4'b1100: w_alu_code = 3'd3;                                     // ORR
      4'b0001: begin                                                  // EOR
        w_alu_code = 3'd4;
        w_dp_legal = (ALUCTL_W >= 3);
      end
      4'b1010: begin                                                  // CMP
        w_alu_code   = 3'd1;
        w_dp_arith   = 1'b1;
        w_dp_nowrite = 1'b1;
        w_dp_legal   = (ALUCTL_W >= 3) && i_funct[0];  // CMP without S is illegal
      end
      default: w_dp_legal = 1'b0;
    endcase
    if (!w_dp_legal) begin
      w_alu_code = 3'd0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Result of the EXEC-stage decode, held for ALUWB and cleared in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nowrite_q <= 1'b0;
      r_illegal_q <= 1'b0;
    end else if (r_state == S_FETCH) begin
      r_nowrite_q <= 1'b0;
      r_illegal_q <= 1'b0;
    end else if (r_state == S_EXECR || r_state == S_EXECI) begin
      r_nowrite_q <= w_dp_nowrite;
      r_illegal_q <= ~w_dp_legal;
    end
  end

  logic       w_ir_write, w_next_pc, w_reg_w, w_mem_w, w_branch, w_exec, w_illegal;
  logic       w_adr_src;
  logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b, w_flag_w;
  logic [2:0] w_alu_ctl;

  always_comb begin
    w_next       = S_FETCH;
    w_ir_write   = 1'b0;
    w_next_pc    = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    w_exec       = 1'b0;
    w_illegal    = 1'b0;
    w_adr_src    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_flag_w     = 2'b00;
    w_alu_ctl    = 3'd0;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_next_pc    = 1'b1;
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        case (i_op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = i_funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_b = 2'b01;
        w_next      = i_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr_src = 1'b1;
        w_next    = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_w      = 1'b1;
      end
      S_MEMWR: begin
        w_adr_src = 1'b1;
        w_mem_w   = 1'b1;
      end
      S_EXECR: begin
        w_exec = 1'b1;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_exec      = 1'b1;
        w_alu_src_b = 2'b01;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_w = ~r_nowrite_q & ~r_illegal_q;
      end
      S_BRANCH: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_branch     = 1'b1;
      end
      default: w_next = S_FETCH;  // codes 10-15 recover to FETCH
    endcase

    if (w_exec) begin
      if (w_dp_legal) begin
        w_alu_ctl = w_alu_code;
        w_flag_w  = {i_funct[0], i_funct[0] & w_dp_arith};
      end else begin
        w_illegal = 1'b1;
      end
    end
  end

  assign o_state       = r_state;
  assign o_adr_src     = w_adr_src;
  assign o_result_src  = w_result_src;
  assign o_alu_src_a   = w_alu_src_a;
  assign o_alu_src_b   = w_alu_src_b;
  assign o_imm_src     = i_op;
  assign o_reg_src     = {i_op == 2'b01, i_op == 2'b10};
  assign o_alu_control = w_alu_ctl[ALUCTL_W-1:0];

  // Strobes are held low for the whole reset pulse, not just after the edge.
  assign o_ir_write = w_ir_write & ~reset;
  assign o_next_pc  = w_next_pc  & ~reset;
  assign o_reg_w    = w_reg_w    & ~reset;
  assign o_mem_w    = w_mem_w    & ~reset;
  assign o_pcs      = ((w_reg_w && i_rd == 4'hF) || w_branch) & ~reset;
  assign o_flag_w   = w_flag_w   & {2{~reset}};
  assign o_illegal  = w_illegal  & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl_fsm
//  Purpose  : Self-checking bench for multicycle_ctrl_fsm. Two instances
//             (ALUCTL_W = 3 and 2) share the same instruction fields.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] i_op;
  logic [5:0] i_funct;
  logic [3:0] i_rd;

  always #5 clk = ~clk;

  logic [3:0] st3, st2;
  logic irw3, npc3, pcs3, rw3, mw3, adr3, ill3;
  logic irw2, npc2, pcs2, rw2, mw2, adr2, ill2;
  logic [1:0] res3, sa3, sb3, imm3, rs3, fw3;
  logic [1:0] res2, sa2, sb2, imm2, rs2, fw2;
  logic [2:0] alu3;
  logic [1:0] alu2;

  multicycle_ctrl_fsm #(.ALUCTL_W(3)) dut3 (
    .clk(clk), .reset(reset), .i_op(i_op), .i_funct(i_funct), .i_rd(i_rd),
    .o_state(st3), .o_ir_write(irw3), .o_next_pc(npc3), .o_pcs(pcs3),
    .o_reg_w(rw3), .o_mem_w(mw3), .o_adr_src(adr3), .o_result_src(res3),
    .o_alu_src_a(sa3), .o_alu_src_b(sb3), .o_imm_src(imm3), .o_reg_src(rs3),
    .o_alu_control(alu3), .o_flag_w(fw3), .o_illegal(ill3)
  );

  multicycle_ctrl_fsm #(.ALUCTL_W(2)) dut2 (
    .clk(clk), .reset(reset), .i_op(i_op), .i_funct(i_funct), .i_rd(i_rd),
    .o_state(st2), .o_ir_write(irw2), .o_next_pc(npc2), .o_pcs(pcs2),
    .o_reg_w(rw2), .o_mem_w(mw2), .o_adr_src(adr2), .o_result_src(res2),
    .o_alu_src_a(sa2), .o_alu_src_b(sb2), .o_imm_src(imm2), .o_reg_src(rs2),
    .o_alu_control(alu2), .o_flag_w(fw2), .o_illegal(ill2)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       irw, npc, pcs, regw, memw, adr;
    logic [1:0] res, sa, sb, imm, rsrc;
    logic [2:0] alu;
    logic [1:0] fw;
    logic       ill;
  } rec_t;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    int          len;
    logic [19:0] seq;   // state of cycle k in seq[4k +: 4]
    logic [2:0]  alu;   // OR of ALUControl over the instruction
    logic [1:0]  fw;    // OR of FlagW
    logic        regw, pcs, ill, memw;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  rec_t obs3 [8];
  rec_t obs2 [8];
  rec_t exp3_q [$];
  rec_t exp2_q [$];

  function automatic rec_t rec3();
    return '{st3, irw3, npc3, pcs3, rw3, mw3, adr3, res3, sa3, sb3, imm3, rs3, alu3, fw3, ill3};
  endfunction

  function automatic rec_t rec2();
    return '{st2, irw2, npc2, pcs2, rw2, mw2, adr2, res2, sa2, sb2, imm2, rs2, {1'b0, alu2}, fw2, ill2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic rec_t mk(input logic [3:0] st, input logic [1:0] op);
    rec_t r;
    r      = '0;
    r.st   = st;
    r.imm  = op;
    r.rsrc = {op == 2'b01, op == 2'b10};
    return r;
  endfunction

  // Builds the expected cycle-by-cycle trace of one instruction.
  task automatic model(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                       input int w, output rec_t q[$]);
    rec_t r;
    logic legal, nowr, arith, s;
    logic [2:0] code;
    q = {};
    r = mk(0, op); r.irw = 1; r.npc = 1; r.sa = 1; r.sb = 2; r.res = 2; q.push_back(r);
    r = mk(1, op); r.sa = 1; r.sb = 2; r.res = 2; r.ill = (op == 2'b11); q.push_back(r);
    if (op == 2'b01) begin
      r = mk(2, op); r.sb = 1; q.push_back(r);
      if (f[0]) begin
        r = mk(3, op); r.adr = 1; q.push_back(r);
        r = mk(4, op); r.res = 1; r.regw = 1; r.pcs = (rd == 4'hF); q.push_back(r);
      end else begin
        r = mk(5, op); r.adr = 1; r.memw = 1; q.push_back(r);
      end
    end else if (op == 2'b10) begin
      r = mk(9, op); r.sa = 2; r.sb = 1; r.res = 2; r.pcs = 1; q.push_back(r);
    end else if (op == 2'b00) begin
      s = f[0]; legal = 1; nowr = 0; arith = 0; code = 0;
      case (f[4:1])
        4'b0100: begin code = 0; arith = 1; end
        4'b0010: begin code = 1; arith = 1; end
        4'b0000: code = 0 + 2;
        4'b1100: code = 3;
        4'b0001: begin code = 4; legal = (w == 3); end
        4'b1010: begin code = 1; arith = 1; nowr = 1; legal = (w == 3) && s; end
        default: legal = 0;
      endcase
      r = mk(f[5] ? 4'd7 : 4'd6, op);
      r.sb = f[5] ? 2'd1 : 2'd0;
      if (legal) begin r.alu = code; r.fw = {s, s & arith}; end
      else r.ill = 1;
      q.push_back(r);
      r = mk(8, op); r.regw = legal & ~nowr; r.pcs = r.regw & (rd == 4'hF); q.push_back(r);
    end
  endtask

  // Entered at a falling edge with the FSM in FETCH; leaves at a falling edge.
  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd, input int n);
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin i_op = op; i_funct = f; i_rd = rd; end
      else @(negedge clk);
      #1;
      obs3[k] = rec3();
      obs2[k] = rec2();
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [2:0] a_alu; logic [1:0] a_fw; logic a_rw, a_pcs, a_ill, a_mw;
    a_alu = 0; a_fw = 0; a_rw = 0; a_pcs = 0; a_ill = 0; a_mw = 0;
    drive(v.op, v.funct, v.rd, v.len);
    for (int k = 0; k < v.len; k++) begin
      chk($sformatf("vec%0d state[%0d]", idx, k), 32'(obs3[k].st), 32'(v.seq[4*k +: 4]));
      a_alu |= obs3[k].alu; a_fw |= obs3[k].fw; a_rw |= obs3[k].regw;
      a_pcs |= obs3[k].pcs; a_ill |= obs3[k].ill; a_mw |= obs3[k].memw;
    end
    chk($sformatf("vec%0d alu", idx),   32'(a_alu), 32'(v.alu));
    chk($sformatf("vec%0d flagw", idx), 32'(a_fw),  32'(v.fw));
    chk($sformatf("vec%0d regw", idx),  32'(a_rw),  32'(v.regw));
    chk($sformatf("vec%0d pcs", idx),   32'(a_pcs), 32'(v.pcs));
    chk($sformatf("vec%0d illegal", idx), 32'(a_ill), 32'(v.ill));
    chk($sformatf("vec%0d memw", idx),  32'(a_mw),  32'(v.memw));
    chk($sformatf("vec%0d back_to_fetch", idx), 32'(st3), 32'd0);
  endtask

  vec_t vecs [12];

  initial begin
    vec_t v;
    rec_t e;
    int   ill_cnt, any_fw, any_rw;
    logic [1:0] rop; logic [5:0] rf; logic [3:0] rrd;

    //          op     funct      rd    len seq        alu fw     rw pcs ill mw
    vecs[0]  = '{2'b00, 6'b001000, 4'h1, 4, 20'h08610, 3'd0, 2'b00, 1, 0, 0, 0}; // ADD
    vecs[1]  = '{2'b01, 6'b011001, 4'h2, 5, 20'h43210, 3'd0, 2'b00, 1, 0, 0, 0}; // LDR
    vecs[2]  = '{2'b01, 6'b011000, 4'h2, 4, 20'h05210, 3'd0, 2'b00, 0, 0, 0, 1}; // STR
    vecs[3]  = '{2'b10, 6'b000000, 4'h0, 3, 20'h00910, 3'd0, 2'b00, 0, 1, 0, 0}; // B
    vecs[4]  = '{2'b00, 6'b010101, 4'h0, 4, 20'h08610, 3'd1, 2'b11, 0, 0, 0, 0}; // CMP
    vecs[5]  = '{2'b00, 6'b011001, 4'hF, 4, 20'h08610, 3'd3, 2'b10, 1, 1, 0, 0}; // ORRS R15
    vecs[6]  = '{2'b11, 6'b000000, 4'h0, 2, 20'h00010, 3'd0, 2'b00, 0, 0, 1, 0}; // Op=11
    vecs[7]  = '{2'b00, 6'b100010, 4'h3, 4, 20'h08710, 3'd4, 2'b00, 1, 0, 0, 0}; // EOR imm
    vecs[8]  = '{2'b00, 6'b100101, 4'h4, 4, 20'h08710, 3'd1, 2'b11, 1, 0, 0, 0}; // SUBS imm
    vecs[9]  = '{2'b00, 6'b010100, 4'h0, 4, 20'h08610, 3'd0, 2'b00, 0, 0, 1, 0}; // CMP S=0
    vecs[10] = '{2'b00, 6'b001110, 4'h5, 4, 20'h08610, 3'd0, 2'b00, 0, 0, 1, 0}; // undefined
    vecs[11] = '{2'b00, 6'b000001, 4'h6, 4, 20'h08610, 3'd2, 2'b10, 1, 0, 0, 0}; // ANDS

    reset = 1'b1; i_op = 2'b00; i_funct = '0; i_rd = '0;
    repeat (2) @(negedge clk);
    #1;
    e = mk(0, 2'b00); e.sa = 1; e.sb = 2; e.res = 2;   // FETCH selects, strobes held low
    chk("reset_state_w3", 32'(rec3()), 32'(e));
    chk("reset_state_w2", 32'(rec2()), 32'(e));
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      run_vec(v, i);
    end

    // CMP on the 2-bit ALU-control variant: one Illegal pulse, no writes
    drive(2'b00, 6'b010101, 4'h0, 4);
    ill_cnt = 0; any_fw = 0; any_rw = 0;
    for (int k = 0; k < 4; k++) begin
      ill_cnt += int'(obs2[k].ill);
      any_fw  |= int'(obs2[k].fw);
      any_rw  |= int'(obs2[k].regw);
    end
    chk("cmp_w2 illegal_pulses", 32'(ill_cnt), 32'd1);
    chk("cmp_w2 illegal_in_exec", 32'(obs2[2].ill), 32'd1);
    chk("cmp_w2 flagw", 32'(any_fw), 32'd0);
    chk("cmp_w2 regw", 32'(any_rw), 32'd0);

    // Branch detail: NextPC only in FETCH, BRANCH mux selects
    drive(2'b10, 6'b000000, 4'h0, 3);
    chk("b nextpc_fetch", 32'(obs3[0].npc), 32'd1);
    chk("b nextpc_rest", 32'(obs3[1].npc | obs3[2].npc), 32'd0);
    chk("b srca", 32'(obs3[2].sa), 32'd2);
    chk("b immsrc", 32'(obs3[2].imm), 32'd2);

    // Reset asserted during MEMWR aborts the store
    i_op = 2'b01; i_funct = 6'b011000; i_rd = 4'h2;
    repeat (3) @(negedge clk);
    #1;
    chk("abort in_memwr", 32'(st3), 32'd5);
    chk("abort memw_before", 32'(mw3), 32'd1);
    chk("abort regsrc", 32'(rs3), 32'd2);
    reset = 1'b1;
    #1;
    chk("abort state_now", 32'(st3), 32'd0);
    chk("abort memw_now", 32'(mw3), 32'd0);
    @(negedge clk); #1;
    chk("abort state_held", 32'(st3), 32'd0);
    chk("abort strobes_held", 32'({mw3, rw3, irw3, npc3, pcs3}), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort fetch_irwrite", 32'(irw3), 32'd1);
    @(negedge clk); #1;
    chk("abort then_decode", 32'(st3), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Randomized instructions against the reference model
    for (int n = 0; n < 300; n++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = 6'($urandom);
      rrd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      model(rop, rf, rrd, 3, exp3_q);
      model(rop, rf, rrd, 2, exp2_q);
      drive(rop, rf, rrd, exp3_q.size());
      for (int k = 0; k < exp3_q.size(); k++) begin
        chk($sformatf("rand%0d w3 cyc%0d op%0d f%02h", n, k, rop, rf), 32'(obs3[k]), 32'(exp3_q[k]));
        chk($sformatf("rand%0d w2 cyc%0d op%0d f%02h", n, k, rop, rf), 32'(obs2[k]), 32'(exp2_q[k]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Control unit for the multicycle version of the ARM-like CPU. It replaces the single-cycle decode with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It adds a parametrised ALU-control width, extended data-processing ops (EOR, CMP) and an illegal-instruction strobe. Condition checking and the flag register live in the downstream conditional unit, which gates RegW, MemW and PCS using CondEx.

Parameters:
ALUCTL_W, 3, ALUControl width. Legal values are 2 and 3. With 2, EOR and CMP decode as unimplemented.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; returns the FSM to FETCH
Op  in  2  instr[27:26] from the instruction register
Funct  in  6  instr[25:20]
Rd  in  4  instr[15:12]
State  out  4  current state code, for debug
IRWrite  out  1  instruction register load enable
NextPC  out  1  PC <= ALU result, unconditional
PCS  out  1  PC-source write request, conditional
RegW  out  1  register file write request, conditional
MemW  out  1  memory write request, conditional
AdrSrc  out  1  0 = PC, 1 = ALU output register
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = RD1, 01 = PC, 10 = ALUOut
ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
ImmSrc  out  2  00 = DP imm8, 01 = mem imm12, 10 = branch imm24
RegSrc  out  2  [0]: Rn = R15; [1]: Rm field = Rd (store)
ALUControl  out  ALUCTL_W  ALU operation select
FlagW  out  2  [1] = N,Z write; [0] = C,V write
Illegal  out  1  one-cycle pulse on an unimplemented instruction

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 are unreachable and go to FETCH.
- Reset: asynchronous to FETCH. While reset is high, IRWrite, NextPC, PCS, RegW, MemW, FlagW and Illegal are forced to 0. Mux selects show FETCH values.
- All outputs are Moore (state-only) except three combinational terms:
  - ImmSrc, RegSrc: decoded from Op every cycle.
  - ALUControl, FlagW: decoded from Funct in the EXEC states.
  - PCS = (RegW & Rd == 4'hF) | BRANCH.
- Unlisted outputs are 0. Default ALUControl is ADD (0).
- Op decode: ImmSrc = Op; RegSrc = {Op == 01, Op == 10}.
- Per-state outputs and next state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1. Next DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next by Op:
    - 01 → MEMADR
    - 00 with Funct[5]=0 → EXECR
    - 00 with Funct[5]=1 → EXECI
    - 10 → BRANCH
    - 11 → FETCH with Illegal=1
  - MEMADR: ALUSrcA=00, ALUSrcB=01. Next MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD: AdrSrc=1. Next MEMWB.
  - MEMWB: ResultSrc=01, RegW=1. Next FETCH.
  - MEMWR: AdrSrc=1, MemW=1. Next FETCH.
  - EXECR: ALUSrcA=00, ALUSrcB=00, ALU decode active. Next ALUWB.
  - EXECI: ALUSrcA=00, ALUSrcB=01, ALU decode active. Next ALUWB.
  - ALUWB: ResultSrc=00. RegW = ~NoWrite_q & ~Illegal_q. Next FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCS=1. Next FETCH.
- Latency: B takes 3 cycles; DP and STR take 4; LDR takes 5.
- ALU decode on Funct[4:1], EXEC states only:
  - 0100 ADD → 0
  - 0010 SUB → 1
  - 0000 AND → 2
  - 1100 ORR → 3
  - 0001 EOR → 4 (ALUCTL_W=3 only)
  - 1010 CMP → SUB code 1 with NoWrite=1. Requires Funct[0]=1; CMP with S=0 is illegal.
  - Anything else → ALUControl=0, FlagW=0, Illegal=1.
- Flag writes:
  - FlagW[1] = Funct[0].
  - FlagW[0] = Funct[0] & (op is ADD, SUB or CMP).
  - FlagW is non-zero only in EXECR/EXECI.
- NoWrite_q and Illegal_q are registered at the end of EXEC and cleared in FETCH. An illegal DP instruction therefore writes nothing in ALUWB, and the FSM still returns to FETCH.
- Reset asserted mid-instruction aborts it: no write strobe may fire after reset, and the first post-reset cycle is FETCH.

Test Plan:
1. Reset, then ADD R1,R2,R3 (Op=00, Funct=001000, Rd=1) → state sequence 0,1,6,8,0; ALUControl=0 in EXECR; RegW=1 only in ALUWB; FlagW=00; PCS=0.
2. LDR (Op=01, Funct=011001), then STR (Funct=011000) → LDR sequence 0,1,2,3,4 with ResultSrc=01 and RegW in MEMWB. STR sequence 0,1,2,5 with MEMWR showing MemW=1, AdrSrc=1, RegSrc=10.
3. B (Op=10) → sequence 0,1,9,0; PCS=1 and ALUSrcA=10, ImmSrc=10 in BRANCH; NextPC=1 only in FETCH.
4. CMP (Funct=010101) with ALUCTL_W=3 → ALUControl=1 and FlagW=11 in EXECR; RegW=0 in ALUWB. Same instruction with ALUCTL_W=2 → Illegal pulses once, FlagW=00, RegW=0.
5. ORRS to R15 (Funct=011001, Rd=F) → FlagW=10 in EXEC; RegW=1 and PCS=1 in ALUWB. Op=11 → Illegal=1 in DECODE, next state FETCH.
6. Assert reset during MEMWR → State=0 immediately; MemW=0 while reset is held; a clean FETCH follows release.
